// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin share of a single binary-to-Gray datapath.
// Winning request is converted and held in one output register, tagged with
// the requester index. valid/ready handshake on every requester and on output.
module gray_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_bin,
  output logic [WIDTH-1:0]         out_gray,
  output logic [ID_W-1:0]          out_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                        state;
  logic [ID_W-1:0]               ptr;
  logic [NUM_REQ-1:0][WIDTH-1:0] lane_data;
  logic                          can_accept;
  logic                          gnt_any;
  logic [ID_W-1:0]               gnt_idx;
  logic [ID_W:0]                 cand;
  logic                          grant;
  logic [WIDTH-1:0]              sel_bin;

  // Flat bus viewed as one WIDTH-wide lane per requester.
  assign lane_data = req_data;

  // Output slot is free if empty or if its current result drains this cycle.
  assign can_accept = (state == EMPTY) || out_ready;

  // Search from the pointer upward, wrapping at NUM_REQ; first valid wins.
  // Only req_valid and the pointer feed this, never the data lanes.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && req_valid[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[ID_W-1:0];
      end
    end
  end

  // Reset suppresses grants so nothing is accepted while it is asserted.
  assign grant = !rst && can_accept && gnt_any;

  // One-hot ready for the winner, zero when nothing is granted.
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_bin   = lane_data[gnt_idx];
  assign out_valid = (state == FULL);

  // Two-state output slot: capture on grant, drain on out_ready, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_bin  <= '0;
      out_gray <= '0;
      out_id   <= '0;
    end else if (grant) begin
      state    <= FULL;
      out_bin  <= sel_bin;
      out_gray <= sel_bin ^ (sel_bin >> 1);
      out_id   <= gnt_idx;
      ptr      <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed vectors with hand-computed expectations.
module tb_gray_conv_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_bin;
  logic [WIDTH-1:0]         out_gray;
  logic [ID_W-1:0]          out_id;

  int checks = 0;
  int fails  = 0;

  gray_conv_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_gray(out_gray), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] b,
                         input logic [3:0] g, input logic [1:0] id);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".bin"},   out_bin,   b);
    chk({tag, ".gray"},  out_gray,  g);
    chk({tag, ".id"},    out_id,    id);
  endtask

  // Hand-derived Gray table for 0..15.
  logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rr_bin  [5] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd3};
  logic [3:0] rr_gray [5] = '{4'b0010, 4'b0101, 4'b1101, 4'b1010, 4'b0010};

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = {4'd12, 4'd9, 4'd6, 4'd3};
    out_ready = 1'b0;

    // Reset held two cycles with every requester valid.
    tick();
    tick();
    chk("rst.ready", req_ready, 4'b0000);
    chk_out("rst", 1'b0, 4'h0, 4'h0, 2'd0);

    // Release: round-robin with all valid, data 3,6,9,12.
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      settle();
      chk($sformatf("rr%0d.ready", n), req_ready, 32'(4'b0001 << rr_id[n]));
      tick();
      chk_out($sformatf("rr%0d", n), 1'b1, rr_bin[n], rr_gray[n], rr_id[n]);
    end

    // Exhaustive conversion through requester 2 alone.
    req_valid = 4'b0100;
    for (int b = 0; b < 16; b++) begin
      req_data = {4'd0, 4'(b), 4'd0, 4'd0};
      settle();
      chk($sformatf("cv%0d.ready", b), req_ready, 4'b0100);
      tick();
      chk_out($sformatf("cv%0d", b), 1'b1, 4'(b), gray_tbl[b], 2'd2);
    end

    // Drain, then make requester 1 hold 0110 in the output slot.
    req_valid = 4'b0000;
    tick();
    chk("drain.valid", out_valid, 1'b0);
    req_valid = 4'b0010;
    req_data  = {4'b1010, 4'd0, 4'b0110, 4'd0};
    out_ready = 1'b0;
    tick();
    chk_out("bp.load", 1'b1, 4'b0110, 4'b0101, 2'd1);

    // Backpressure: req 3 waits while out_ready is low.
    req_valid = 4'b1000;
    for (int n = 0; n < 3; n++) begin
      settle();
      chk($sformatf("bp%0d.ready", n), req_ready, 4'b0000);
      tick();
      chk_out($sformatf("bp%0d", n), 1'b1, 4'b0110, 4'b0101, 2'd1);
    end
    out_ready = 1'b1;
    settle();
    chk("bp.rel.ready", req_ready, 4'b1000);
    tick();
    chk_out("bp.rel", 1'b1, 4'b1010, 4'b1111, 2'd3);

    // Pointer hold across idle cycles.
    req_valid = 4'b0010;
    req_data  = {4'd0, 4'd7, 4'd5, 4'd1};
    tick();
    chk_out("ph.g1", 1'b1, 4'd5, 4'b0111, 2'd1);
    req_valid = 4'b0000;
    for (int n = 0; n < 5; n++) tick();
    chk("ph.idle.valid", out_valid, 1'b0);
    chk("ph.idle.hold", out_bin, 4'd5);
    req_valid = 4'b0101;
    settle();
    chk("ph.a.ready", req_ready, 4'b0100);
    tick();
    chk_out("ph.a", 1'b1, 4'd7, 4'b0100, 2'd2);
    settle();
    chk("ph.b.ready", req_ready, 4'b0001);
    tick();
    chk_out("ph.b", 1'b1, 4'd1, 4'b0001, 2'd0);

    // Move pointer to 3, then reset mid-operation while FULL and stalled.
    req_valid = 4'b0100;
    tick();
    chk("mr.pre.id", out_id, 2'd2);
    req_valid = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    chk_out("mr", 1'b0, 4'h0, 4'h0, 2'd0);
    rst       = 1'b0;
    req_valid = 4'b1010;
    req_data  = {4'd9, 4'd0, 4'd15, 4'd0};
    out_ready = 1'b1;
    settle();
    chk("mr.ready", req_ready, 4'b0010);
    tick();
    chk_out("mr.g", 1'b1, 4'd15, 4'b1000, 2'd1);
    settle();
    chk("mr.next.ready", req_ready, 4'b1000);
    tick();
    chk_out("mr.next", 1'b1, 4'd9, 4'b1101, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one binary-to-Gray conversion datapath between NUM_REQ requesters, using round-robin arbitration and a valid/ready handshake on every port.
- Each granted request is converted (g = b ^ (b >> 1)) and captured in a single output register, tagged with the requester index.
- Sits between multiple producers of binary codes (counters, encoders) and a single downstream consumer of Gray codes.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 4, bit width of each binary code and of the Gray result.
- ID_W, 2, width of out_id; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i set: requester i presents data.
- req_data  input  NUM_REQ*WIDTH  requester i uses bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot or zero; bit i set: requester i accepted this cycle.
- out_valid  output  1  output register holds a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_bin  output  WIDTH  captured binary input.
- out_gray  output  WIDTH  Gray code of out_bin.
- out_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0; out_bin=0; out_gray=0; out_id=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
  - Reset wins over any handshake in the same cycle; a pending result is discarded and not retried.
- Transfer rule: a transfer occurs on a port when valid and ready are both 1 at the rising edge.
- State machine, 2 states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = (state==EMPTY) || (out_ready==1). can_accept is combinational, so a new request is accepted in the same cycle the old result drains.
- Arbitration (combinational):
  - When can_accept=1 and any req_valid=1, grant the first set req_valid bit found by searching from the pointer upward, modulo NUM_REQ.
  - req_ready = one-hot of the grant; otherwise req_ready=0.
  - req_ready must not depend on req_data.
- On grant of index k, at the next edge:
  - out_bin <= req_data[k]; out_gray <= req_data[k] ^ (req_data[k] >> 1); out_id <= k.
  - state <= FULL; pointer <= (k+1) mod NUM_REQ.
- No grant:
  - out_ready=1 while FULL: state <= EMPTY; data registers hold their last values.
  - out_ready=0 while FULL: all outputs hold stable (out_bin, out_gray, out_id unchanged).
- Latency: 1 cycle from request acceptance to out_valid.
- Throughput: 1 result per cycle while out_ready stays 1.
- The pointer advances only on a grant. An idle cycle does not move priority.
- A requester that drops req_valid before being granted loses nothing; it is not remembered.
- Fairness: with all requesters continuously valid and out_ready=1, grants follow 0,1,...,NUM_REQ-1,0,...
- Gray arithmetic is unsigned and width-preserving.
  - MSB passes through unchanged.
  - Wrap: bin all-ones maps to Gray 1000..0, e.g. WIDTH=4: 1111 -> 1000.
- out_ready while EMPTY is ignored.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all req_valid=1 -> req_ready=0000, out_valid=0, out_bin=0, out_gray=0, out_id=0; after release, the first grant goes to requester 0.
- Exhaustive conversion: requester 2 alone, out_ready=1, bin 0..15 -> each result one cycle later with out_id=2. Spot checks: 0101 -> 0111, 1000 -> 1100, 1111 -> 1000.
- Round-robin: all four req_valid=1 with data 3,6,9,12 and out_ready=1 -> grant order 0,1,2,3,0. out_gray sequence 0010, 0101, 1101, 1010, 0010; exactly one req_ready bit per cycle.
- Backpressure: FULL with out_id=1 and out_bin=0110, then out_ready=0 for 3 cycles while req 3 is valid -> req_ready=0000, outputs stable at 0110/0101/1. Raise out_ready -> req 3 granted the same cycle, and its result appears on the next edge.
- Pointer hold: grant req 1, idle 5 cycles, then req 0 and req 2 both valid -> req 2 granted first (pointer=2), req 0 next.
- Mid-operation reset: FULL with out_ready=0, assert rst for 1 cycle -> out_valid=0 and the pointer returns to 0; with req 1 and req 3 valid afterwards, req 1 is granted first.
